engine_sample_decimator: RTL



---
 rtl/engine_sample_decimator.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/engine_sample_decimator.sv
// Box-car decimator for the engine sound sample stream: averages 2^DECIM_LOG2
// enabled samples, applies a saturating gain and buffers results in a 2-deep FIFO.
module engine_sample_decimator #(
    parameter int IN_W       = 16,
    parameter int DECIM_LOG2 = 6,
    parameter int GAIN_SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_3MHz_en,
    input  logic signed [IN_W-1:0] in_sample,
    output logic signed [IN_W-1:0] out_sample,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overrun,
    input  logic                   clr_overrun
);

    localparam int ACC_W = IN_W + DECIM_LOG2;
    localparam int SH_W  = ACC_W + GAIN_SHIFT;

    localparam logic [DECIM_LOG2-1:0] CNT_MAX = {DECIM_LOG2{1'b1}};
    localparam logic signed [SH_W-1:0] SAT_MAX = {{(SH_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
    localparam logic signed [SH_W-1:0] SAT_MIN = {{(SH_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};

    logic signed [ACC_W-1:0]      acc_r;
    logic        [DECIM_LOG2-1:0] cnt_r;

    logic signed [IN_W-1:0] mem_r [2];
    logic                   rd_ptr_r;
    logic                   wr_ptr_r;
    logic        [1:0]      count_r;

    logic signed [IN_W-1:0] out_sample_r;
    logic                   out_valid_r;
    logic                   overrun_r;

    logic signed [ACC_W-1:0] in_ext_s;
    logic signed [ACC_W-1:0] total_s;
    logic signed [ACC_W-1:0] avg_s;
    logic signed [SH_W-1:0]  shifted_s;
    logic signed [IN_W-1:0]  res_s;

    logic                   block_end_s;
    logic                   pop_s;
    logic                   push_ok_s;
    logic                   drop_s;
    logic signed [IN_W-1:0] mem_n_s [2];
    logic                   rd_ptr_n_s;
    logic                   wr_ptr_n_s;
    logic        [1:0]      count_n_s;
    logic signed [IN_W-1:0] head_n_s;

    // Block result datapath: final sum, floor average, gain and saturation.
    always_comb begin
        in_ext_s  = ACC_W'(in_sample);
        total_s   = acc_r + in_ext_s;
        avg_s     = total_s >>> DECIM_LOG2;
        shifted_s = SH_W'(avg_s) <<< GAIN_SHIFT;
        if (shifted_s > SAT_MAX) begin
            res_s = SAT_MAX[IN_W-1:0];
        end else if (shifted_s < SAT_MIN) begin
            res_s = SAT_MIN[IN_W-1:0];
        end else begin
            res_s = shifted_s[IN_W-1:0];
        end
    end

    // Handshake decisions; a full buffer still accepts a push if it pops this cycle.
    always_comb begin
        pop_s       = out_valid_r & out_ready;
        block_end_s = clk_3MHz_en & (cnt_r == CNT_MAX);
        push_ok_s   = block_end_s & ((count_r != 2'd2) | pop_s);
        drop_s      = block_end_s & ~push_ok_s;
    end

    // Next FIFO state, used both for the storage and for the registered head.
    always_comb begin
        mem_n_s[0] = mem_r[0];
        mem_n_s[1] = mem_r[1];
        if (push_ok_s) begin
            mem_n_s[wr_ptr_r] = res_s;
            wr_ptr_n_s        = ~wr_ptr_r;
        end else begin
            wr_ptr_n_s        = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_n_s = ~rd_ptr_r;
        end else begin
            rd_ptr_n_s = rd_ptr_r;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_n_s = count_r + 2'd1;
            2'b01:   count_n_s = count_r - 2'd1;
            default: count_n_s = count_r;
        endcase
        head_n_s = mem_n_s[rd_ptr_n_s];
    end

    // Accumulator and block counter advance only on enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (clk_3MHz_en) begin
            if (block_end_s) begin
                acc_r <= '0;
                cnt_r <= '0;
            end else begin
                acc_r <= total_s;
                cnt_r <= cnt_r + {{(DECIM_LOG2-1){1'b0}}, 1'b1};
            end
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            mem_r[0] <= mem_n_s[0];
            mem_r[1] <= mem_n_s[1];
            rd_ptr_r <= rd_ptr_n_s;
            wr_ptr_r <= wr_ptr_n_s;
            count_r  <= count_n_s;
        end
    end

    // Registered head of buffer; holds its value while the buffer is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sample_r <= '0;
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r <= (count_n_s != 2'd0);
            if (count_n_s != 2'd0) begin
                out_sample_r <= head_n_s;
            end else begin
                out_sample_r <= out_sample_r;
            end
        end
    end

    // Sticky overrun: a drop wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (clr_overrun) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign out_sample = out_sample_r;
    assign out_valid  = out_valid_r;
    assign overrun    = overrun_r;

endmodule
